// File: rtl/mul32_seq_ctrl.sv
// rtl/mul32_seq_ctrl.sv - 32x32 unsigned multiply sequenced over one shared 16x16 daddamul
module daddamul (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);
  assign p = {16'b0, x} * {16'b0, y};
endmodule

module mul32_seq_ctrl #(
  parameter bit REG_PROD  = 1'b1,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DRAIN, S_DONE} state_t;

  state_t      state, state_d;
  logic [31:0] a_q, b_q;
  logic [3:0]  mask_q, mask_in;
  logic [63:0] acc;
  logic [1:0]  step, step_sh;
  logic        issue, last_step;
  logic [15:0] mul_x, mul_y;
  logic [31:0] mul_p;
  logic [31:0] prod_q;
  logic [1:0]  prod_sh_q;
  logic        prod_v_q;

  // Shift code: 0 -> <<0, 1 -> <<16, 2 -> <<32.
  function automatic logic [63:0] shifted(input logic [31:0] p, input logic [1:0] sh);
    case (sh)
      2'd1:    shifted = {16'b0, p, 16'b0};
      2'd2:    shifted = {p, 32'b0};
      default: shifted = {32'b0, p};
    endcase
  endfunction

  daddamul u_mul (.x(mul_x), .y(mul_y), .p(mul_p));

  always_comb begin
    mask_in = 4'hf;
    if (SKIP_ZERO) begin
      mask_in[0] = (|a[15:0])  & (|b[15:0]);
      mask_in[1] = (|a[15:0])  & (|b[31:16]);
      mask_in[2] = (|a[31:16]) & (|b[15:0]);
      mask_in[3] = (|a[31:16]) & (|b[31:16]);
    end
  end

  // mask_q holds the steps still to issue; the lowest set bit is the current step.
  always_comb begin
    step = 2'd0;
    casez (mask_q)
      4'b???1: step = 2'd0;
      4'b??10: step = 2'd1;
      4'b?100: step = 2'd2;
      4'b1000: step = 2'd3;
      default: step = 2'd0;
    endcase
    step_sh   = (step == 2'd0) ? 2'd0 : ((step == 2'd3) ? 2'd2 : 2'd1);
    issue     = (state == S_CALC) && (mask_q != 4'd0);
    last_step = (mask_q & (mask_q - 4'd1)) == 4'd0;
    mul_x     = 16'd0;
    mul_y     = 16'd0;
    if (issue) begin
      mul_x = step[1] ? a_q[31:16] : a_q[15:0];
      mul_y = step[0] ? b_q[31:16] : b_q[15:0];
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (in_valid) state_d = S_CALC;
      S_CALC:  if (last_step) state_d = REG_PROD ? S_DRAIN : S_DONE;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      mask_q    <= 4'd0;
      acc       <= 64'd0;
      prod_q    <= 32'd0;
      prod_sh_q <= 2'd0;
      prod_v_q  <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= 64'd0;
            mask_q   <= mask_in;
            prod_v_q <= 1'b0;
          end
        end
        S_CALC: begin
          mask_q <= mask_q & (mask_q - 4'd1);
          if (REG_PROD) begin
            // Product lags one cycle; accumulate the one captured last cycle.
            prod_q    <= mul_p;
            prod_sh_q <= step_sh;
            prod_v_q  <= issue;
            if (prod_v_q) acc <= acc + shifted(prod_q, prod_sh_q);
          end else if (issue) begin
            acc <= acc + shifted(mul_p, step_sh);
          end
        end
        S_DRAIN: begin
          if (prod_v_q) acc <= acc + shifted(prod_q, prod_sh_q);
          prod_v_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign result    = acc;
endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb/tb_mul32_seq_ctrl.sv - self-checking bench for mul32_seq_ctrl in two parameter configurations
module tb_mul32_seq_ctrl;
  localparam bit RP0 = 1'b1, SZ0 = 1'b0;
  localparam bit RP1 = 1'b0, SZ1 = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid[2], in_ready[2], out_valid[2], out_ready[2], busy[2];
  logic [31:0] a[2], b[2];
  logic [63:0] result[2];
  int          cyc = 0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul32_seq_ctrl #(.REG_PROD(RP0), .SKIP_ZERO(SZ0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .busy(busy[0]));

  mul32_seq_ctrl #(.REG_PROD(RP1), .SKIP_ZERO(SZ1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .busy(busy[1]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] av, input logic [31:0] bv);
    return {32'b0, av} * {32'b0, bv};
  endfunction

  // Cycles from accept edge until out_valid is seen: max(1, live half-pairs) + REG_PROD + 1.
  function automatic int ref_lat(input int d, input logic [31:0] av, input logic [31:0] bv);
    int n;
    bit rp, sz;
    logic [15:0] ah, bh;
    rp = (d == 0) ? RP0 : RP1;
    sz = (d == 0) ? SZ0 : SZ1;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        ah = av[16*i +: 16];
        bh = bv[16*j +: 16];
        if (!sz || (ah != 16'd0 && bh != 16'd0)) n++;
      end
    end
    if (n == 0) n = 1;
    return n + int'(rp) + 1;
  endfunction

  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input bit hold_iv, input string tag, output int acc_cyc);
    int n;
    logic [63:0] exp_r;
    int exp_l;
    exp_r = ref_prod(av, bv);
    exp_l = ref_lat(d, av, bv);
    a[d] = av;
    b[d] = bv;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept"}, 64'(in_ready[d]), 64'd1);
    acc_cyc = cyc;
    @(negedge clk);
    if (!hold_iv) begin
      in_valid[d] = 1'b0;
      a[d] = $urandom;
      b[d] = $urandom;
    end
    n = 1;
    while (!out_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_l));
    check({tag, " result"}, result[d], exp_r);
    @(negedge clk);
    check({tag, " valid width"}, 64'(out_valid[d]), 64'd0);
  endtask

  initial begin
    int t0, t1, n, d;
    logic [31:0] ra, rb;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
      a[i] = 32'd0;
      b[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    check("rst in_ready0", 64'(in_ready[0]), 64'd0);
    check("rst in_ready1", 64'(in_ready[1]), 64'd0);
    check("rst out_valid0", 64'(out_valid[0]), 64'd0);
    check("rst busy1", 64'(busy[1]), 64'd0);
    rst = 1'b0;
    #1;
    check("idle in_ready0", 64'(in_ready[0]), 64'd1);
    check("idle in_ready1", 64'(in_ready[1]), 64'd1);
    check("idle result0", result[0], 64'd0);
    check("idle busy0", 64'(busy[0]), 64'd0);
    @(negedge clk);

    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max_d0", t0);
    run_op(1, 32'h0000_1234, 32'h0000_5678, 1'b0, "one_step_d1", t0);
    run_op(1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, "empty_d1", t0);
    run_op(0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, "zero_noskip_d0", t0);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max_d1", t0);

    // Result must hold while the consumer stalls, and DONE accepts nothing new.
    a[0] = 32'h0001_0000;
    b[0] = 32'h0001_0000;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b0;
    n = 0;
    while (!in_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 1;
    while (!out_valid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stall latency", 64'(n), 64'(ref_lat(0, 32'h0001_0000, 32'h0001_0000)));
    for (int i = 0; i < 10; i++) begin
      check("stall result", result[0], ref_prod(32'h0001_0000, 32'h0001_0000));
      check("stall out_valid", 64'(out_valid[0]), 64'd1);
      check("stall in_ready", 64'(in_ready[0]), 64'd0);
      in_valid[0] = (i % 2 == 1);
      a[0] = $urandom;
      b[0] = $urandom;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("stall release out_valid", 64'(out_valid[0]), 64'd0);
    check("stall release in_ready", 64'(in_ready[0]), 64'd1);
    check("stall release busy", 64'(busy[0]), 64'd0);
    run_op(0, 32'h0000_0007, 32'h0000_000B, 1'b0, "after_stall_d0", t0);

    for (int k = 0; k < 2; k++) begin
      run_op(k, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "b2b_first", t0);
      run_op(k, 32'h0000_0003, 32'h0000_0005, 1'b1, "b2b_second", t1);
      in_valid[k] = 1'b0;
      check("b2b period", 64'(t1 - t0), 64'(ref_lat(k, 32'h1234_5678, 32'h9ABC_DEF0) + 1));
    end

    // Abort an operation mid-CALC (third step pending) with a one-cycle reset.
    a[0] = 32'hFFFF_FFFF;
    b[0] = 32'hFFFF_FFFF;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    n = 0;
    while (!in_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("mid busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort in_ready low", 64'(in_ready[0]), 64'd0);
    rst = 1'b0;
    #1;
    check("abort in_ready", 64'(in_ready[0]), 64'd1);
    check("abort out_valid", 64'(out_valid[0]), 64'd0);
    check("abort result", result[0], 64'd0);
    check("abort busy", 64'(busy[0]), 64'd0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[0]) n++;
    end
    check("abort no valid", 64'(n), 64'd0);
    run_op(0, 32'd7, 32'd9, 1'b0, "after_abort_d0", t0);

    for (int i = 0; i < 24; i++) begin
      d = i % 2;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra[15:0] = 16'd0;
        1: rb[31:16] = 16'd0;
        2: begin ra[31:16] = 16'd0; rb[15:0] = 16'd0; end
        3: ra = 32'd0;
        default: ;
      endcase
      run_op(d, ra, rb, 1'b0, "random", t0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
